// File: rtl/display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_pkg : shared types/constants for the BCD display path    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package display_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_digit_adjust : double-dabble add-3 correction for one digit  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bcd_digit_adjust
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/binary_to_bcd_digits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | binary_to_bcd_digits : sequential double-dabble converter with   |
// | sign, overflow saturation and leading-zero blanking. Rev 1.0     |
// +------------------------------------------------------------------+
module binary_to_bcd_digits
    import display_pkg::*;
#(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [BIN_WIDTH-1:0]              binary,
    output logic                              ready,
    output logic                              done,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]             blank,
    output logic                              negative,
    output logic                              overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int SCR_W = BCD_DIGIT_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] BLANK_RESET = ~NUM_DIGITS'(1);

    conv_state_t          r_state;
    conv_state_t          w_next_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [BIN_WIDTH-1:0] w_magnitude;
    logic [SCR_W-1:0]     r_scratch;
    logic [SCR_W-1:0]     w_adjusted;
    logic [SCR_W-1:0]     w_final_digits;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [CNT_W-1:0]     r_count;
    logic                 r_neg;
    logic                 r_ovf;
    logic                 w_is_neg;

    generate
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .digit_in  (r_scratch [d*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (w_adjusted[d*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Negating in BIN_WIDTH bits maps the most negative value onto its true magnitude.
    assign w_is_neg    = SIGNED && binary[BIN_WIDTH-1];
    assign w_magnitude = w_is_neg ? (~binary + BIN_WIDTH'(1)) : binary;

    assign w_final_digits = r_ovf ? {NUM_DIGITS{BCD_NINE}} : r_scratch;

    always_comb begin
        w_blank    = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            w_blank[i] = ((w_final_digits >> (BCD_DIGIT_W * i)) == '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (r_count == '0) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (r_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            done      <= 1'b0;
            digits    <= '0;
            blank     <= BLANK_RESET;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= w_magnitude;
                        r_neg     <= w_is_neg;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_count   <= CNT_W'(BIN_WIDTH - 1);
                    end
                end
                SHIFT: begin
                    // A carry out of the top digit means the value cannot be shown.
                    r_scratch <= {w_adjusted[SCR_W-2:0], r_shift[BIN_WIDTH-1]};
                    r_shift   <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    r_ovf     <= r_ovf | w_adjusted[SCR_W-1];
                    r_count   <= r_count - CNT_W'(1);
                end
                FINISH: begin
                    digits   <= w_final_digits;
                    blank    <= w_blank;
                    negative <= r_neg;
                    overflow <= r_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : binary_to_bcd_digits
`default_nettype wire

// File: tb/tb_binary_to_bcd_digits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_binary_to_bcd_digits : randomized bench, unsigned 16/4 and    |
// | signed 8/3 instances against an arithmetic reference. Rev 1.0    |
// +------------------------------------------------------------------+
module tb_binary_to_bcd_digits;

    logic        clk = 1'b0;
    logic        reset;

    logic        start_a;
    logic [15:0] binary_a;
    logic        ready_a, done_a, negative_a, overflow_a;
    logic [15:0] digits_a;
    logic [3:0]  blank_a;

    logic        start_b;
    logic [7:0]  binary_b;
    logic        ready_b, done_b, negative_b, overflow_b;
    logic [11:0] digits_b;
    logic [2:0]  blank_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    binary_to_bcd_digits #(.BIN_WIDTH(16), .NUM_DIGITS(4), .SIGNED(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .binary(binary_a),
        .ready(ready_a), .done(done_a), .digits(digits_a), .blank(blank_a),
        .negative(negative_a), .overflow(overflow_a)
    );

    binary_to_bcd_digits #(.BIN_WIDTH(8), .NUM_DIGITS(3), .SIGNED(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .binary(binary_b),
        .ready(ready_b), .done(done_b), .digits(digits_b), .blank(blank_b),
        .negative(negative_b), .overflow(overflow_b)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: plain arithmetic on the magnitude, decimal digits by div/mod.
    function automatic void ref_model(input longint raw, input int bw, input int nd,
                                      input bit sgn, output logic [15:0] dig,
                                      output logic [3:0] blk, output logic neg,
                                      output logic ovf);
        longint mag, limit, sat, v;
        if (sgn && raw >= (longint'(1) << (bw - 1))) begin
            mag = (longint'(1) << bw) - raw;
            neg = 1'b1;
        end else begin
            mag = raw;
            neg = 1'b0;
        end
        limit = longint'(10 ** nd) - 1;
        ovf   = (mag > limit);
        sat   = ovf ? limit : mag;
        v     = sat;
        dig   = '0;
        blk   = '0;
        for (int i = 0; i < nd; i++) begin
            dig[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        for (int i = 1; i < nd; i++) blk[i] = (sat < longint'(10 ** i));
    endfunction

    task automatic convert_a(input logic [15:0] val);
        logic [15:0] ed; logic [3:0] eb; logic en, eo;
        int edges; bit busy_ok;
        string t;
        ref_model(longint'(val), 16, 4, 1'b0, ed, eb, en, eo);
        t = $sformatf("a(%0d)", val);
        @(negedge clk);
        check_value({t, " ready idle"}, 32'(ready_a), 32'd1);
        start_a  = 1'b1;
        binary_a = val;
        @(negedge clk);
        start_a  = 1'b0;
        binary_a = 16'($urandom);
        edges    = 0;
        busy_ok  = 1'b1;
        while (!done_a && edges < 40) begin
            if (ready_a) busy_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        check_value({t, " latency"}, 32'(edges), 32'd17);
        check_value({t, " ready low busy"}, 32'(busy_ok), 32'd1);
        check_value({t, " digits"}, 32'(digits_a), 32'(ed));
        check_value({t, " blank"}, 32'(blank_a), 32'(eb));
        check_value({t, " negative"}, 32'(negative_a), 32'(en));
        check_value({t, " overflow"}, 32'(overflow_a), 32'(eo));
        @(negedge clk);
        check_value({t, " done pulse"}, 32'(done_a), 32'd0);
        check_value({t, " digits hold"}, 32'(digits_a), 32'(ed));
    endtask

    task automatic convert_b(input logic [7:0] val);
        logic [15:0] ed; logic [3:0] eb; logic en, eo;
        int edges;
        string t;
        ref_model(longint'(val), 8, 3, 1'b1, ed, eb, en, eo);
        t = $sformatf("b(%0h)", val);
        @(negedge clk);
        start_b  = 1'b1;
        binary_b = val;
        @(negedge clk);
        start_b  = 1'b0;
        binary_b = 8'($urandom);
        edges    = 0;
        while (!done_b && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check_value({t, " latency"}, 32'(edges), 32'd9);
        check_value({t, " digits"}, 32'(digits_b), 32'(ed[11:0]));
        check_value({t, " blank"}, 32'(blank_b), 32'(eb[2:0]));
        check_value({t, " negative"}, 32'(negative_b), 32'(en));
        check_value({t, " overflow"}, 32'(overflow_b), 32'(eo));
    endtask

    initial begin
        logic [15:0] q_val[$];
        logic [15:0] ed, front; logic [3:0] eb; logic en, eo;
        logic [15:0] dir_a[6] = '{16'd1234, 16'd7, 16'd0, 16'd65535, 16'd9999, 16'd10000};
        logic [7:0]  dir_b[6] = '{8'hF6, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'd100};
        int cyc, last_done, results, accepted;
        bit saw_done;

        reset = 1'b1; start_a = 1'b0; binary_a = '0; start_b = 1'b0; binary_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_value("rst digits", 32'(digits_a), 32'd0);
        check_value("rst blank", 32'(blank_a), 32'b1110);
        check_value("rst ready", 32'(ready_a), 32'd1);
        check_value("rst done", 32'(done_a), 32'd0);
        check_value("rst flags", 32'({negative_a, overflow_a}), 32'd0);
        check_value("rst blank b", 32'(blank_b), 32'b110);

        foreach (dir_a[i]) convert_a(dir_a[i]);
        foreach (dir_b[i]) convert_b(dir_b[i]);
        for (int i = 0; i < 15; i++) convert_a(16'($urandom));
        for (int i = 0; i < 15; i++) convert_b(8'($urandom));

        // start held high with a new value each cycle
        cyc = 0; last_done = -1; results = 0; accepted = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_a) begin
                front = (q_val.size() > 0) ? q_val.pop_front() : 16'd0;
                ref_model(longint'(front), 16, 4, 1'b0, ed, eb, en, eo);
                check_value("b2b digits", 32'(digits_a), 32'(ed));
                check_value("b2b overflow", 32'(overflow_a), 32'(eo));
                if (last_done >= 0) check_value("b2b interval", 32'(cyc - last_done), 32'd18);
                last_done = cyc;
                results++;
            end
            start_a  = (cyc < 170);
            binary_a = 16'($urandom);
            if (ready_a && start_a) begin
                q_val.push_back(binary_a);
                accepted++;
            end
        end
        start_a = 1'b0;
        check_value("b2b results", 32'(results), 32'(accepted));

        // reset during conversion
        @(negedge clk);
        start_a = 1'b1; binary_a = 16'd4321;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("abort digits", 32'(digits_a), 32'd0);
        check_value("abort blank", 32'(blank_a), 32'b1110);
        check_value("abort ready", 32'(ready_a), 32'd1);
        check_value("abort done", 32'(done_a), 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        check_value("abort no done", 32'(saw_done), 32'd0);
        convert_a(16'd4321);
        convert_a(16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_binary_to_bcd_digits
`default_nettype wire
